// File: rtl/my_sync_fifo.sv
// rtl/my_sync_fifo.sv - show-ahead synchronous FIFO; almost flags enabled by FIFO_ALMOST_FLAGS_EN
module my_sync_fifo #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 8,
    parameter int AW        = $clog2(DEPTH),
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Reject unusable configurations at elaboration time
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_TH > DEPTH || AEMPTY_TH > DEPTH
        || WIDTH < 1) begin : g_bad_cfg
        $error("my_sync_fifo: illegal parameter combination");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_ok, wr_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign rd_data   = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A read frees a slot in the same cycle, so a write into a full queue is
    // accepted when paired with a successful read
    assign rd_ok = rd_en && !empty;
    assign wr_ok = wr_en && (!full || rd_ok);

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [AW:0] AFULL_CNT  = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AEMPTY_CNT = (AW + 1)'(AEMPTY_TH);
    assign almost_full  = (count_q >= AFULL_CNT);
    assign almost_empty = (count_q <= AEMPTY_CNT);
`else
    assign almost_full  = 1'b0;
    assign almost_empty = 1'b0;
`endif

    // Next-state for pointers, occupancy and sticky error flags; clr wins over traffic
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
            // Setting beats clearing when both happen in one cycle
            if (wr_en && !wr_ok) begin
                overflow_d = 1'b1;
            end else if (rd_ok) begin
                overflow_d = 1'b0;
            end
            if (rd_en && !rd_ok) begin
                underflow_d = 1'b1;
            end else if (wr_ok) begin
                underflow_d = 1'b0;
            end
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are left untouched by reset and flush
    always_ff @(posedge clk) begin
        if (wr_ok && !clr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_my_sync_fifo.sv
// tb/tb_my_sync_fifo.sv - scoreboard testbench for my_sync_fifo
module tb_my_sync_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        wr_en;
    logic [11:0] wr_data;
    logic        rd_en;
    logic [11:0] rd_data;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    logic [11:0] sb[$];
    bit          m_over;
    bit          m_under;

    my_sync_fifo #(.WIDTH(12), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty), .count(count),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic bit exp_af();
`ifdef FIFO_ALMOST_FLAGS_EN
        return sb.size() >= 6;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit exp_ae();
`ifdef FIFO_ALMOST_FLAGS_EN
        return sb.size() <= 2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive(input bit wr, input logic [11:0] d, input bit rd,
                         output logic [11:0] got, output logic [11:0] exp, output bit popped);
        bit rd_ok;
        bit wr_ok;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        rd_ok   = rd && (sb.size() > 0);
        wr_ok   = wr && (sb.size() < 8 || rd_ok);
        popped  = rd_ok;
        got     = rd_data;
        exp     = 12'h000;
        if (rd_ok) exp = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        if (wr && !wr_ok) m_over = 1'b1;
        else if (rd_ok)   m_over = 1'b0;
        if (rd && !rd_ok) m_under = 1'b1;
        else if (wr_ok)   m_under = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        sb.delete();
        m_over  = 1'b0;
        m_under = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        m_over = 1'b0; m_under = 1'b0;
        #2;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b exp 10", empty, full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b%b exp 00", overflow, underflow); end
        checks++; if (almost_full !== exp_af() || almost_empty !== exp_ae()) begin errors++; $display("FAIL reset_almost got %b%b exp %b%b", almost_full, almost_empty, exp_af(), exp_ae()); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [11:0] g, e;
        bit p;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 12'(i), 1'b0, g, e, p);
            checks++; if (count !== 4'(sb.size())) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, sb.size()); end
            checks++; if (almost_full !== exp_af()) begin errors++; $display("FAIL fill_afull got %b exp %b at count %0d", almost_full, exp_af(), sb.size()); end
        end
        checks++; if (full !== 1'b1 || count !== 4'd8) begin errors++; $display("FAIL fill_full got full=%b count=%0d exp full=1 count=8", full, count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_overflow got %b exp 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [11:0] g, e;
        bit p;
        drive(1'b1, 12'h009, 1'b0, g, e, p);
        checks++; if (count !== 4'd8 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got count=%0d ovf=%b exp count=8 ovf=1", count, overflow); end
        drive(1'b0, 12'h000, 1'b1, g, e, p);
        checks++; if (!p || g !== 12'h001 || e !== 12'h001) begin errors++; $display("FAIL ovf_read got %h exp 001", g); end
        checks++; if (overflow !== m_over || count !== 4'd7) begin errors++; $display("FAIL ovf_clear got ovf=%b count=%0d exp ovf=0 count=7", overflow, count); end
    endtask

    task automatic test_full_simul();
        logic [11:0] g, e;
        bit p;
        do_clr();
        for (int i = 1; i <= 8; i++) drive(1'b1, 12'(i), 1'b0, g, e, p);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 12'h0AA, 1'b1, g, e, p);
            checks++; if (!p || g !== e || e !== 12'(i)) begin errors++; $display("FAIL simul_pop got %h exp %h", g, e); end
            checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL simul_count got count=%0d full=%b exp 8/1", count, full); end
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 12'h000, 1'b1, g, e, p);
            checks++; if (!p || g !== e) begin errors++; $display("FAIL simul_drain got %h exp %h", g, e); end
        end
        checks++; if (g !== 12'h0AA) begin errors++; $display("FAIL simul_last got %h exp 0aa", g); end
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL simul_empty got empty=%b count=%0d exp 1/0", empty, count); end
    endtask

    task automatic test_underflow();
        logic [11:0] g, e;
        bit p;
        drive(1'b0, 12'h000, 1'b1, g, e, p);
        checks++; if (underflow !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL udf_set got udf=%b count=%0d exp 1/0", underflow, count); end
        drive(1'b1, 12'h0BB, 1'b1, g, e, p);
        checks++; if (count !== 4'd1 || rd_data !== 12'h0BB) begin errors++; $display("FAIL udf_simul got count=%0d data=%h exp 1/0bb", count, rd_data); end
        checks++; if (underflow !== m_under) begin errors++; $display("FAIL udf_keep got %b exp %b", underflow, m_under); end
        drive(1'b1, 12'h0BC, 1'b0, g, e, p);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear got %b exp 0", underflow); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 12'h000, 1'b1, g, e, p);
            checks++; if (!p || g !== e) begin errors++; $display("FAIL udf_drain got %h exp %h", g, e); end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] g, e;
        bit p;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) drive(1'b1, 12'(12'h100 + r * 16 + i), 1'b0, g, e, p);
            for (int i = 0; i < 5; i++) begin
                drive(1'b0, 12'h000, 1'b1, g, e, p);
                checks++; if (!p || g !== e) begin errors++; $display("FAIL wrap_data got %h exp %h", g, e); end
            end
            checks++; if (empty !== 1'b1 || almost_empty !== exp_ae()) begin errors++; $display("FAIL wrap_empty got %b%b exp 1%b", empty, almost_empty, exp_ae()); end
        end
    endtask

    task automatic test_clr_rst();
        logic [11:0] g, e;
        bit p;
        for (int i = 0; i < 5; i++) drive(1'b1, 12'(12'h300 + i), 1'b0, g, e, p);
        checks++; if (count !== 4'd5 || almost_full !== exp_af() || almost_empty !== exp_ae()) begin errors++; $display("FAIL clr_pre got count=%0d af=%b ae=%b", count, almost_full, almost_empty); end
        wr_en = 1'b1; wr_data = 12'h777;
        do_clr();
        wr_en = 1'b0;
        checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL clr_wr got count=%0d empty=%b exp 0/1", count, empty); end
        for (int i = 0; i < 7; i++) drive(1'b1, 12'(12'h400 + i), 1'b0, g, e, p);
        wr_en = 1'b1; wr_data = 12'h4FF;
        #3;
        rst = 1'b1;
        #1;
        sb.delete(); m_over = 1'b0; m_under = 1'b0;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL arst_flags got count=%0d empty=%b full=%b", count, empty, full); end
        checks++; if (almost_full !== exp_af() || almost_empty !== exp_ae() || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL arst_other got %b%b%b%b", almost_full, almost_empty, overflow, underflow); end
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_after got empty=%b exp 1", empty); end
        drive(1'b1, 12'h5A5, 1'b0, g, e, p);
        drive(1'b0, 12'h000, 1'b1, g, e, p);
        checks++; if (!p || g !== 12'h5A5 || g !== e) begin errors++; $display("FAIL arst_data got %h exp 5a5", g); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_full_simul();
        test_underflow();
        test_wrap();
        test_clr_rst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
